frame_strobe_sequencer: RTL and testbench



---
 rtl/frame_strobe_sequencer.sv | 150 +++++++++++++++
 tb/tb_frame_strobe_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer
// Loads one fabric column's configuration latches from a stream of header/data
// word pairs. It sequences data setup, a one-hot strobe window of STROBE_CYCLES
// and a data hold cycle for every frame write. Every output is a flop.
module frame_strobe_sequencer #(
   parameter int unsigned FRAME_BITS    = 32,
   parameter int unsigned MAX_FRAMES    = 20,
   parameter int unsigned STROBE_CYCLES = 2,       // legal range 1..15
   parameter logic [15:0] SYNC          = 16'hFAB0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [31:0]           s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [FRAME_BITS-1:0] FrameData,
   output logic [MAX_FRAMES-1:0] FrameStrobe,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err,
   output logic [15:0]           frames_written
);

   // The strobe counter is loaded with N-1 so STROBE lasts exactly N cycles.
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic [MAX_FRAMES-1:0] strobe_q, strobe_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [15:0]           count_q, count_d;

   logic                  accept;
   logic                  hdr_ok;

   // A word moves only on a handshake. ready_q is a flop, so it is low during
   // the reset cycle and no word can be taken while RST is held.
   assign accept = s_valid & ready_q;
   assign hdr_ok = (s_data[31:16] == SYNC) && (32'(s_data[7:0]) < MAX_FRAMES);

   // State register: all sequencer state and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic: header decode, data wait and the strobe window countdown
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && hdr_ok) begin
               idx_d   = s_data[7:0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = STROBE_LOAD;
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: outputs are decoded from the next state, so the registered
   // values line up with the state the FSM occupies in the same cycle.
   always_comb begin
      ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_HOLD);
      err_d   = (state_q == ST_IDLE) && accept && !hdr_ok;
      // FrameData changes only on a data word, never while a strobe bit is set.
      data_d  = data_q;
      if ((state_q == ST_DATA) && accept) begin
         data_d = s_data[FRAME_BITS-1:0];
      end
      count_d = count_q;
      if ((state_d == ST_HOLD) && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   // One strobe bit per frame. The bit is set only in STROBE and only at the
   // latched index, so the bus is at most one-hot.
   for (genvar gi = 0; gi < MAX_FRAMES; gi++) begin : g_strobe
      assign strobe_d[gi] = (state_d == ST_STROBE) && (idx_q == 8'(gi));
   end

   assign s_ready        = ready_q;
   assign FrameData      = data_q;
   assign FrameStrobe    = strobe_q;
   assign busy           = busy_q;
   assign frame_done     = done_q;
   assign err            = err_q;
   assign frames_written = count_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Self-checking bench for frame_strobe_sequencer: hand-written timing
// sequences, a table of header/data records, and a strobe monitor that checks
// every frame write against a scoreboard queue.
module tb_frame_strobe_sequencer;
   localparam int FB = 32;
   localparam int MF = 20;
   localparam int SC = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic [31:0]   s_data;
   logic          s_valid;
   logic          s_ready;
   logic [FB-1:0] FrameData;
   logic [MF-1:0] FrameStrobe;
   logic          busy;
   logic          frame_done;
   logic          err;
   logic [15:0]   frames_written;

   always #5 CLK = ~CLK;

   frame_strobe_sequencer #(
      .FRAME_BITS(FB),
      .MAX_FRAMES(MF),
      .STROBE_CYCLES(SC),
      .SYNC(16'hFAB0)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .FrameData(FrameData),
      .FrameStrobe(FrameStrobe),
      .busy(busy),
      .frame_done(frame_done),
      .err(err),
      .frames_written(frames_written)
   );

   int checks = 0;
   int failures = 0;
   int done_count = 0;
   int fw_exp = 0;

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] hdr;
      logic [31:0] data;
      bit          ok;
   } vec_t;
   vec_t vt[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present a word and hold it until accepted; returns cycles spent waiting.
   task automatic send(input logic [31:0] w, output int waited);
      waited = 0;
      s_data = w;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && waited < 64) begin
         step();
         waited++;
      end
      check("send_ready", {31'b0, s_ready}, 32'd1);
      step();
      s_valid = 1'b0;
      $display("tx word=%h waited=%0d t=%0t", w, waited, $time);
   endtask

   // Wait (bounded) for the HOLD cycle of the current write.
   task automatic wait_done();
      int n = 0;
      while (frame_done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("frame_done_seen", {31'b0, frame_done}, 32'd1);
      fw_exp++;
      check("frames_written", {16'b0, frames_written}, 32'(fw_exp));
   endtask

   // Strobe monitor: pops the scoreboard at the start of each strobe window
   // and checks index, data, one-hotness, window length and data stability.
   logic [MF-1:0] prev_strobe;
   logic [FB-1:0] prev_data;
   logic [MF-1:0] one_hot;
   int            strobe_len;
   exp_t          e;
   always @(negedge CLK) begin
      if (RST !== 1'b0) begin
         prev_strobe = '0;
         strobe_len = 0;
      end else begin
         if (FrameStrobe != '0) begin
            check("strobe_onehot", {31'b0, $onehot(FrameStrobe)}, 32'd1);
            if (prev_strobe == '0) begin
               check("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  one_hot = MF'(1) << e.idx;
                  check("strobe_index", 32'(FrameStrobe), 32'(one_hot));
                  check("strobe_data", FrameData, e.data);
                  $display("frame idx=%0d data=%h strobe=%h t=%0t", e.idx, FrameData, FrameStrobe, $time);
               end
               strobe_len = 1;
            end else begin
               strobe_len++;
               check("strobe_stable", 32'(FrameStrobe), 32'(prev_strobe));
            end
         end
         if (prev_strobe != '0) begin
            checks++;
            assert (FrameData === prev_data) else begin
               failures++;
               $display("FAIL data_stable: got %h expected %h (t=%0t)", FrameData, prev_data, $time);
            end
         end
         if (frame_done === 1'b1) begin
            check("strobe_len", 32'(strobe_len), 32'(SC));
            done_count++;
            strobe_len = 0;
         end
         prev_strobe = FrameStrobe;
         prev_data = FrameData;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int dc;
      logic [31:0] d;

      vt[0] = '{32'h1234_0003, 32'h0, 1'b0};  // bad sync
      vt[1] = '{32'hFAB0_0014, 32'h0, 1'b0};  // idx 20, out of range
      vt[2] = '{32'hFAB0_0013, 32'hCAFE_F00D, 1'b1};  // last frame
      vt[3] = '{32'hFAB0_FF02, 32'h0F0F_0F0F, 1'b1};  // bits [15:8] ignored
      vt[4] = '{32'hFAB0_00FF, 32'h0, 1'b0};  // idx 255
      vt[5] = '{32'hFAB1_0001, 32'h0, 1'b0};  // one-bit sync error
      vt[6] = '{32'hFAB0_0000, 32'hFAB0_0014, 1'b1};  // data looks like a header

      // Reset with s_valid high: nothing accepted, all outputs at reset values
      RST = 1'b1;
      s_valid = 1'b1;
      s_data = 32'hFAB0_0005;
      step();
      step();
      check("rst_s_ready", {31'b0, s_ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_FrameData", FrameData, 32'd0);
      check("rst_FrameStrobe", 32'(FrameStrobe), 32'd0);
      check("rst_frame_done", {31'b0, frame_done}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_frames_written", {16'b0, frames_written}, 32'd0);
      RST = 1'b0;
      s_valid = 1'b0;
      step();
      check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
      check("post_rst_busy", {31'b0, busy}, 32'd0);

      // Single write, cycle by cycle
      send(32'hFAB0_0005, w);
      check("single_data_busy", {31'b0, busy}, 32'd1);
      check("single_data_ready", {31'b0, s_ready}, 32'd1);
      send(32'hDEAD_BEEF, w);
      sb.push_back('{8'd5, 32'hDEAD_BEEF});
      check("setup_strobe", 32'(FrameStrobe), 32'd0);
      check("setup_data", FrameData, 32'hDEAD_BEEF);
      check("setup_ready", {31'b0, s_ready}, 32'd0);
      step();
      check("strobe1", 32'(FrameStrobe), 32'h0002_0);
      step();
      check("strobe2", 32'(FrameStrobe), 32'h0002_0);
      check("strobe2_done", {31'b0, frame_done}, 32'd0);
      step();
      check("hold_strobe", 32'(FrameStrobe), 32'd0);
      check("hold_done", {31'b0, frame_done}, 32'd1);
      check("hold_data", FrameData, 32'hDEAD_BEEF);
      fw_exp = 1;
      check("hold_count", {16'b0, frames_written}, 32'd1);
      step();
      check("idle_done", {31'b0, frame_done}, 32'd0);
      check("idle_ready", {31'b0, s_ready}, 32'd1);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Table of headers, accepted and rejected
      for (int i = 0; i < 7; i++) begin
         send(vt[i].hdr, w);
         if (vt[i].ok) begin
            check("tbl_busy", {31'b0, busy}, 32'd1);
            send(vt[i].data, w);
            sb.push_back('{vt[i].hdr[7:0], vt[i].data});
            wait_done();
            step();
            check("tbl_idle", {31'b0, busy}, 32'd0);
         end else begin
            check("tbl_err", {31'b0, err}, 32'd1);
            check("tbl_rej_busy", {31'b0, busy}, 32'd0);
            check("tbl_rej_strobe", 32'(FrameStrobe), 32'd0);
            step();
            check("tbl_err_pulse", {31'b0, err}, 32'd0);
            check("tbl_rej_idle", {31'b0, busy}, 32'd0);
         end
      end

      // Stall in DATA, then backpressure while the write runs
      send(32'hFAB0_0000, w);
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_strobe", 32'(FrameStrobe), 32'd0);
      end
      check("stall_busy", {31'b0, busy}, 32'd1);
      send(32'h0000_0001, w);
      sb.push_back('{8'd0, 32'h0000_0001});
      dc = done_count;
      send(32'hFAB0_0009, w);
      check("backpressure_wait", 32'(w), 32'(SC + 2));
      check("backpressure_done", 32'(done_count), 32'(dc + 1));
      fw_exp++;
      check("backpressure_count", {16'b0, frames_written}, 32'(fw_exp));
      send(32'hA5A5_5A5A, w);
      sb.push_back('{8'd9, 32'hA5A5_5A5A});
      wait_done();
      step();

      // Reset in the first STROBE cycle
      send(32'hFAB0_0007, w);
      send(32'h1111_2222, w);
      step();
      check("mid_strobe", 32'(FrameStrobe), 32'h0000_0080);
      RST = 1'b1;
      step();
      check("mid_rst_strobe", 32'(FrameStrobe), 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_done", {31'b0, frame_done}, 32'd0);
      check("mid_rst_count", {16'b0, frames_written}, 32'd0);
      RST = 1'b0;
      sb.delete();
      fw_exp = 0;
      dc = done_count;
      for (int i = 0; i < 5; i++) step();
      check("after_rst_no_done", 32'(done_count), 32'(dc));
      check("after_rst_count", {16'b0, frames_written}, 32'd0);
      check("after_rst_ready", {31'b0, s_ready}, 32'd1);

      // Full column, frames 0..19 back to back
      dc = done_count;
      for (int i = 0; i < MF; i++) begin
         d = $urandom;
         send(32'hFAB0_0000 | 32'(i), w);
         send(d, w);
         sb.push_back('{8'(i), d});
      end
      for (int n = 0; n < 40 && busy !== 1'b0; n++) step();
      check("column_idle", {31'b0, busy}, 32'd0);
      check("column_done", 32'(done_count - dc), 32'(MF));
      check("column_count", {16'b0, frames_written}, 32'(MF));
      check("column_sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
